// File: rtl/keypad_emu_pkg.sv
// Shared keypad definitions: press-sequence states, key fields, LFSR.
// Also used by the scanner side for the key-field layout.
package keypad_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BOUNCE_DN = 3'd1,
        ST_HELD      = 3'd2,
        ST_BOUNCE_UP = 3'd3,
        ST_GAP       = 3'd4
    } state_e;

    localparam int KEY_ROW_LSB = 2;
    localparam int KEY_COL_LSB = 0;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [1:0] key_row(input logic [3:0] k);
        return k[KEY_ROW_LSB +: 2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] k);
        return k[KEY_COL_LSB +: 2];
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/keypad_emu_if.sv
// Request/press handshake plus the row/column matrix lines.
// master = scanner/test side, slave = keypad emulator.
interface keypad_emu_if;

    logic       req;
    logic [3:0] key_code;
    logic       busy;
    logic       done;
    logic [3:0] fila;
    logic [3:0] columna;

    modport master (
        output req,
        output key_code,
        output fila,
        input  busy,
        input  done,
        input  columna
    );

    modport slave (
        input  req,
        input  key_code,
        input  fila,
        output busy,
        output done,
        output columna
    );

endinterface

// File: rtl/keypad_emu_lfsr8.sv
// 8-bit Fibonacci LFSR, advances only when step is high.
// Reusable for other pseudo-random needs in the game.
module lfsr8
    import keypad_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // next value: shift with feedback on step, else hold
    always_comb begin
        q_d = q_q;
        if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    // register, seeded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/keypad_emu.sv
// 4x4 keypad responder: presses one latched key with bounce, hold,
// release bounce and a quiet gap; answers row strobes on columna.
module keypad_emu
    import keypad_defs::*;
#(
    parameter int BOUNCE_CYCLES = 64,
    parameter int BOUNCE_PERIOD = 4,
    parameter int HOLD_CYCLES   = 256,
    parameter int GAP_CYCLES    = 32
) (
    input logic         clk,
    input logic         rst_n,
    keypad_emu_if.slave kp
);

    localparam int MAX_A = (BOUNCE_CYCLES > HOLD_CYCLES) ?
                           BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_B = (BOUNCE_PERIOD > GAP_CYCLES) ?
                           BOUNCE_PERIOD : GAP_CYCLES;
    localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_V) + 1;
    localparam int PW    = $clog2(BOUNCE_PERIOD) + 1;
    localparam bit HAS_B = (BOUNCE_CYCLES > 0);

    localparam logic [CW-1:0] LD_B =
        HAS_B ? CW'(BOUNCE_CYCLES - 1) : '0;
    localparam logic [CW-1:0] LD_H = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LD_G = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] LD_P = PW'(BOUNCE_PERIOD - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [PW-1:0] per_q;
    logic [PW-1:0] per_d;
    logic          contact_q;
    logic          contact_d;
    logic          done_q;
    logic          done_d;
    logic [3:0]    key_q;
    logic [3:0]    key_d;
    logic          lfsr_step;
    logic [7:0]    lfsr_q;
    logic [7:0]    lfsr_nx;
    logic          cnt_zero;
    logic          bouncing;

    assign cnt_zero = (cnt_q == '0);
    assign bouncing = (state_q == ST_BOUNCE_DN) ||
                      (state_q == ST_BOUNCE_UP);
    assign lfsr_nx  = lfsr_next(lfsr_q);

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: every active state leaves when its counter hits 0
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (kp.req) begin
                    state_d = HAS_B ? ST_BOUNCE_DN : ST_HELD;
                end
            end
            ST_BOUNCE_DN: begin
                if (cnt_zero) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (cnt_zero) begin
                    state_d = HAS_B ? ST_BOUNCE_UP : ST_GAP;
                end
            end
            ST_BOUNCE_UP: begin
                if (cnt_zero) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // counters, contact, key latch and LFSR stepping
    always_comb begin
        cnt_d     = cnt_q;
        per_d     = per_q;
        contact_d = contact_q;
        done_d    = 1'b0;
        key_d     = key_q;
        lfsr_step = 1'b0;
        if (state_q == ST_IDLE && kp.req) begin
            key_d = kp.key_code;
        end
        if (state_d != state_q) begin
            unique case (state_d)
                ST_BOUNCE_DN: begin
                    cnt_d     = LD_B;
                    per_d     = LD_P;
                    contact_d = 1'b1;
                end
                ST_HELD: begin
                    cnt_d     = LD_H;
                    contact_d = 1'b1;
                end
                ST_BOUNCE_UP: begin
                    cnt_d     = LD_B;
                    per_d     = LD_P;
                    contact_d = 1'b0;
                end
                ST_GAP: begin
                    cnt_d     = LD_G;
                    contact_d = 1'b0;
                end
                default: begin
                    contact_d = 1'b0;
                    done_d    = 1'b1;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            cnt_d = cnt_q - 1'b1;
            if (bouncing) begin
                if (per_q == '0) begin
                    per_d     = LD_P;
                    lfsr_step = 1'b1;
                    contact_d = lfsr_nx[0];
                end else begin
                    per_d = per_q - 1'b1;
                end
            end
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            per_q     <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            key_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            key_q     <= key_d;
        end
    end

    // outputs: status and the passive switch matrix (fila -> columna)
    always_comb begin
        kp.busy    = (state_q != ST_IDLE);
        kp.done    = done_q;
        kp.columna = 4'hF;
        if (contact_q && !kp.fila[key_row(key_q)]) begin
            kp.columna[key_col(key_q)] = 1'b0;
        end
    end

endmodule
